divider_8bit: RTL
=================

# divider_8bit

Unsigned 8-bit sequential restoring divider for the Lab 5 datapath. It is the inverse operation of the 8-bit shift-add multiplier. It shares the same switch-and-button front end: S switches, Run, and ClearA_LoadB. It shares the same register display convention: A, B and X, with the A/B values shown on four hex digits. The dividend is loaded into B and the divisor is taken from S at Run. After 16 iteration cycles, B holds the quotient and A holds the remainder.

## Interface
- No parameters; datapath width is fixed at 8.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ClearA_LoadB  in  1  level, synchronous; in READY: A←0, B←S, X←0.
- Run  in  1  level, synchronous; in READY starts a division with divisor S.
- S  in  8  switch input: dividend for ClearA_LoadB, divisor for Run.
- Aval  out  8  A register: partial remainder, final remainder.
- Bval  out  8  B register: dividend, shifting to quotient.
- Mval  out  8  latched divisor.
- X  out  1  bit shifted out of A (9th remainder bit).
- Busy  out  1  high in SHIFT/SUB states.
- DivZero  out  1  set when the latched divisor is 0; cleared at next Run start.
- AhexU, AhexL, BhexU, BhexL  out  7 each  active-low 7-seg, bit order [6:0]=gfedcba, for Aval[7:4], Aval[3:0], Bval[7:4], Bval[3:0].

## Operation
- States: READY, SHIFT, SUB, DONE; 3-bit iteration counter cnt.
- READY, ClearA_LoadB=1: A←0, B←S, X←0; state stays READY. ClearA_LoadB has priority over Run in the same cycle.
- READY, Run=1, ClearA_LoadB=0: M←S, DivZero←(S==0), cnt←0, go SHIFT. A and B are not modified.
- SHIFT: {X,A,B} ← {A,B,1'b0}; go SUB.
- SUB:
  - Compute 9-bit diff = {X,A} − {1'b0,M}.
  - If no borrow: A←diff[7:0], B[0]←1.
  - Else: A unchanged, B[0]←0.
  - X←0 in both cases.
  - If cnt==7, go DONE; else cnt←cnt+1 and go SHIFT.
- DONE: registers hold. Go READY only when Run=0, so a held Run never restarts.
- ClearA_LoadB is ignored in SHIFT, SUB and DONE. S changes after the Run start have no effect.
- Divide by zero needs no special path; the algorithm naturally yields Bval=0xFF and Aval=original dividend, with DivZero=1.
- Results: Bval=floor(B0/M), Aval=B0 mod M, X=0 in DONE.
- Hex decoders are combinational, digits 0–F, standard segment patterns. Examples: '0'=1000000, '1'=1111001, 'C'=1000110, 'F'=0001110.

## Timing
- Reset asynchronous: state=READY, A=B=M=0, X=0, cnt=0, DivZero=0, Busy=0. All four hex digits show '0' (1000000).
- Reset asserted mid-division aborts immediately to the reset values. After deassertion, state is READY.
- Run start: Run is sampled in READY at edge k. Busy=1 from k through k+16. State is DONE after edge k+16, and results are valid from then on.
- Exactly 16 iteration edges per division: 8 SHIFT and 8 SUB, alternating, starting with SHIFT.
- DONE→READY on the first edge with Run=0. A new Run needs a 0→1 cycle with at least one cycle low.
- ClearA_LoadB takes effect on one edge in READY. Held high, it keeps reloading B from S.

## Test plan
- Reset, then check: Aval=Bval=Mval=0x00, X=0, Busy=0, DivZero=0, all hex=1000000.
- ClearA_LoadB with S=0xC8, then Run with S=0x07:
  - Busy high for 16 cycles.
  - DONE: Bval=0x1C, Aval=0x04, X=0, BhexU=1111001, BhexL=1000110.
- Edge cases:
  - Load 0xFF, divide by 0x01 → Bval=0xFF, Aval=0x00.
  - Load 0x05, divide by 0x09 → Bval=0x00, Aval=0x05.
  - Load 0xFF, divide by 0xFF → Bval=0x01, Aval=0x00.
- Load 0x64, Run with S=0x00 → Bval=0xFF, Aval=0x64, DivZero=1. Next Run with S=0x03 clears DivZero.
- Run held high through DONE for 40 cycles → no restart, results stable. ClearA_LoadB pulsed during Busy and DONE → ignored. Release Run → READY.
- Assert Reset at iteration edge 8 of 0xC8/0x07, asynchronously between clock edges → outputs go to reset values without waiting for a clock edge. A later ClearA_LoadB+Run performs a correct fresh division.

Source files
------------

// File: rtl/divider_8bit_if.sv
// divider_8bit_if: switch/button front end and register/display outputs of the 8-bit divider
interface divider_8bit_if;
  logic       ClearA_LoadB;
  logic       Run;
  logic [7:0] S;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic [7:0] Mval;
  logic       X;
  logic       Busy;
  logic       DivZero;
  logic [6:0] AhexU;
  logic [6:0] AhexL;
  logic [6:0] BhexU;
  logic [6:0] BhexL;
  modport master (
    output ClearA_LoadB, Run, S,
    input  Aval, Bval, Mval, X, Busy, DivZero, AhexU, AhexL, BhexU, BhexL
  );
  modport slave (
    input  ClearA_LoadB, Run, S,
    output Aval, Bval, Mval, X, Busy, DivZero, AhexU, AhexL, BhexU, BhexL
  );
endinterface

// File: rtl/divider_8bit.sv
// divider_8bit: unsigned 8-bit restoring divider, B becomes quotient and A remainder after 16 iteration edges
module divider_8bit (
  input logic          Clk,
  input logic          Reset,
  divider_8bit_if.slave bus
);
  typedef enum logic [1:0] {READY, SHIFT, SUB, DONE} state_t;
  state_t     state;
  logic [7:0] a, b, m;
  logic       x, busy, div_zero;
  logic [2:0] cnt;
  logic [9:0] diff;
  logic       borrow;
  // one extra bit so a true borrow is seen even when {x,a} and m are both large
  assign diff   = {1'b0, x, a} - {2'b00, m};
  assign borrow = diff[9];
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
  endfunction
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= READY;
      a        <= 8'h00;
      b        <= 8'h00;
      m        <= 8'h00;
      x        <= 1'b0;
      cnt      <= 3'd0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        READY: begin
          if (bus.ClearA_LoadB) begin
            a <= 8'h00;
            b <= bus.S;
            x <= 1'b0;
          end else if (bus.Run) begin
            m        <= bus.S;
            div_zero <= bus.S == 8'h00;
            cnt      <= 3'd0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {x, a, b} <= {a, b, 1'b0};
          state     <= SUB;
        end
        SUB: begin
          a    <= borrow ? a : diff[7:0];
          b[0] <= ~borrow;
          x    <= 1'b0;
          cnt  <= cnt == 3'd7 ? cnt : cnt + 3'd1;
          busy <= cnt != 3'd7;
          state <= cnt == 3'd7 ? DONE : SHIFT;
        end
        DONE: state <= bus.Run ? DONE : READY;
      endcase
    end
  end
  assign bus.Aval    = a;
  assign bus.Bval    = b;
  assign bus.Mval    = m;
  assign bus.X       = x;
  assign bus.Busy    = busy;
  assign bus.DivZero = div_zero;
  assign bus.AhexU   = seg(a[7:4]);
  assign bus.AhexL   = seg(a[3:0]);
  assign bus.BhexU   = seg(b[7:4]);
  assign bus.BhexL   = seg(b[3:0]);
endmodule
